// File: rtl/cyclic_bram_pkg.sv
// ---------------------------------------------------------------------------
// cyclic_bram_pkg
// Shared definitions for the always-valid cyclic BRAM and its write-side
// filler: the filler state enum and the address-width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cyclic_bram_pkg;

    // Filler FSM states: accepting a frame, letting the final write commit,
    // and holding a complete frame for cyclic readout.
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        DRAIN  = 2'd1,
        LOADED = 2'd2
    } fill_state_t;

    // Address/length width for a given depth. A depth of 1 still needs one
    // bit so that the counter and wrap-point registers exist.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cyclic_bram_filler_if.sv
// ---------------------------------------------------------------------------
// cyclic_bram_filler_if
// Valid/ready input stream carrying one frame into the cyclic BRAM filler.
//   s_valid  beat valid        (source -> filler)
//   s_ready  beat ready        (filler -> source)
//   s_data   beat data, WIDTH  (source -> filler)
//   s_last   last beat marker  (source -> filler)
// Modports: master = upstream source, slave = filler.
// ---------------------------------------------------------------------------
interface cyclic_bram_filler_if #(
    parameter int WIDTH = 64
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/cyclic_bram_filler.sv
// ---------------------------------------------------------------------------
// cyclic_bram_filler
// Write-side front end of the always-valid cyclic BRAM. Accepts one frame
// from a valid/ready stream, writes it word by word into the BRAM, records
// the frame length minus one as the readout wrap point and then holds the
// BRAM loaded until release_req, after which the next frame is accepted.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clken          global clock enable shared with the BRAM
//   s              input stream (cyclic_bram_filler_if.slave)
//   m_valid_ready  BRAM write strobe (BRAM is always ready)
//   m_data         BRAM write data, WIDTH bits
//   addr_max_1     frame length minus 1, ADDR_WIDTH bits
//   loaded         BRAM holds a complete frame
//   release_req    single-cycle request to discard the frame and refill
//                  (named release_req because "release" is an SV keyword)
//   overflow       sticky: a frame exceeded DEPTH beats and was truncated
// ---------------------------------------------------------------------------
module cyclic_bram_filler
    import cyclic_bram_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    cyclic_bram_filler_if.slave   s,
    output logic                  m_valid_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic [ADDR_WIDTH-1:0] addr_max_1,
    output logic                  loaded,
    input  logic                  release_req,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    fill_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] wr_cnt, wr_cnt_next;
    logic                  strobe_next;
    logic [WIDTH-1:0]      data_next;
    logic [ADDR_WIDTH-1:0] addr_max_next;
    logic                  loaded_next;
    logic                  overflow_next;
    logic                  handshake;

    // Ready depends only on state and the enable, never on s_valid, so the
    // source may wait for ready without a combinational loop.
    assign s.s_ready = clken & (state == FILL);
    assign handshake = s.s_valid & s.s_ready;

    // Next-state and next-output logic. Every register defaults to holding
    // its value; the strobe is explicitly cleared in every state and only
    // set for a cycle after an accepted beat.
    always_comb begin
        state_next    = state;
        wr_cnt_next   = wr_cnt;
        strobe_next   = 1'b0;
        data_next     = m_data;
        addr_max_next = addr_max_1;
        loaded_next   = loaded;
        overflow_next = overflow;

        unique case (state)
            FILL: begin
                if (handshake) begin
                    strobe_next = 1'b1;
                    data_next   = s.s_data;
                    wr_cnt_next = wr_cnt + 1'b1;
                    // A frame ends on s_last or when the BRAM is full; in
                    // the full-without-last case the tail is left upstream
                    // and becomes the start of the next frame.
                    if (s.s_last || (wr_cnt == LAST_ADDR)) begin
                        addr_max_next = wr_cnt;
                        wr_cnt_next   = '0;
                        state_next    = DRAIN;
                        if (!s.s_last) begin
                            overflow_next = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                // One cycle so the final strobe commits before readout.
                state_next  = LOADED;
                loaded_next = 1'b1;
            end
            LOADED: begin
                if (release_req) begin
                    state_next  = FILL;
                    loaded_next = 1'b0;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // State and output registers. With clken low everything holds, which
    // keeps the strobe level but the BRAM is gated by the same enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            wr_cnt        <= '0;
            m_valid_ready <= 1'b0;
            m_data        <= '0;
            addr_max_1    <= '0;
            loaded        <= 1'b0;
            overflow      <= 1'b0;
        end else if (clken) begin
            state         <= state_next;
            wr_cnt        <= wr_cnt_next;
            m_valid_ready <= strobe_next;
            m_data        <= data_next;
            addr_max_1    <= addr_max_next;
            loaded        <= loaded_next;
            overflow      <= overflow_next;
        end
    end

endmodule
